// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave and its RAM: FSM states, command codes and defaults.
// Ports: none (package).
// Latency/backpressure: not applicable.
package spi_pkg;

   localparam int MEM_DEPTH_DEF = 256;
   localparam int ADDR_SIZE_DEF = 8;

   // Frame length after the select bit: 2 command bits + 8 payload bits.
   localparam logic [3:0] FRAME_LEN = 4'd10;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

endpackage

// File: rtl/spi_wrapper_if.sv
// Link between the SPI slave front end (master side) and the RAM (slave side).
// Ports: rx_data/rx_valid carry a completed frame; dout/tx_valid return read data.
// Latency/backpressure: no backpressure; rx_valid and tx_valid are single-cycle pulses.
interface spi_wrapper_if;

   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] dout;
   logic       tx_valid;

   modport master (output rx_data, output rx_valid, input dout, input tx_valid);
   modport slave  (input rx_data, input rx_valid, output dout, output tx_valid);

endinterface

// File: rtl/spi_ram.sv
// Single-port RAM decoding SPI frame commands: latch write/read address, write data, read data.
// Ports: clk, rst (sync, active-high); bus (slave side of spi_wrapper_if).
// Latency: dout/tx_valid one cycle after rx_valid; no backpressure, contents survive reset.
module spi_ram
   import spi_pkg::*;
#(
   parameter int MEM_DEPTH = MEM_DEPTH_DEF,
   parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
   input  logic          clk,
   input  logic          rst,
   spi_wrapper_if.slave  bus
);

   logic [7:0]           mem [MEM_DEPTH];
   logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
   logic [7:0]           dout_q, dout_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 mem_we;

   always_comb begin
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      dout_d     = dout_q;
      tx_valid_d = 1'b0;
      mem_we     = 1'b0;
      if (bus.rx_valid) begin
         case (bus.rx_data[9:8])
            CMD_WR_ADDR: wr_addr_d = bus.rx_data[ADDR_SIZE-1:0];
            CMD_WR_DATA: mem_we    = 1'b1;
            CMD_RD_ADDR: rd_addr_d = bus.rx_data[ADDR_SIZE-1:0];
            default: begin
               // Read uses the previously latched address; payload bits are don't-care.
               dout_d     = mem[rd_addr_q];
               tx_valid_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         dout_q     <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         dout_q     <= dout_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   // Storage has no reset; reset only suppresses a write landing on the same edge.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[wr_addr_q] <= bus.rx_data[7:0];
      end
   end

   assign bus.dout     = dout_q;
   assign bus.tx_valid = tx_valid_q;

endmodule

// File: rtl/spi_wrapper.sv
// SPI slave: select bit + 10-bit MSB-first frames drive a RAM; read data shifted out on MISO.
// Ports: clk, rst_n (sync, active-high), SS_n (active-low select), MOSI in, MISO out (registered).
// Latency: rx_valid 1 cycle after 10th bit, MISO MSB 2 cycles after that; no backpressure.
module spi_wrapper
   import spi_pkg::*;
#(
   parameter int MEM_DEPTH = MEM_DEPTH_DEF,
   parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO
);

   state_e     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [9:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       rd_addr_flag_q, rd_addr_flag_d;
   logic [2:0] tx_cnt_q, tx_cnt_d;
   logic [2:0] tx_idx;
   logic       miso_q, miso_d;

   spi_wrapper_if u_bus ();

   assign u_bus.rx_data  = rx_data_q;
   assign u_bus.rx_valid = rx_valid_q;

   spi_ram #(
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_ram (
      .clk (clk),
      .rst (rst_n),
      .bus (u_bus)
   );

   assign tx_idx = tx_cnt_q - 3'd1;

   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      rd_addr_flag_d = rd_addr_flag_q;
      tx_cnt_d       = tx_cnt_q;
      miso_d         = 1'b0;

      if (SS_n) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         tx_cnt_d  = '0;
      end else begin
         case (state_q)
            IDLE:    state_d = CHK_CMD;
            CHK_CMD: begin
               bit_cnt_d = '0;
               if (!MOSI)              state_d = WRITE;
               else if (rd_addr_flag_q) state_d = READ_DATA;
               else                     state_d = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
               // Counter parks at FRAME_LEN so trailing bits are dropped until SS_n rises.
               if (bit_cnt_q != FRAME_LEN) begin
                  rx_data_d = {rx_data_q[8:0], MOSI};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == FRAME_LEN - 4'd1) begin
                     rx_valid_d = 1'b1;
                     if (state_q == READ_ADD)  rd_addr_flag_d = 1'b1;
                     if (state_q == READ_DATA) rd_addr_flag_d = 1'b0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase

         // MSB leaves on the tx_valid edge; tx_cnt then counts the remaining 7 bits.
         if (u_bus.tx_valid) begin
            miso_d   = u_bus.dout[7];
            tx_cnt_d = 3'd7;
         end else if (tx_cnt_q != 3'd0) begin
            miso_d   = u_bus.dout[tx_idx];
            tx_cnt_d = tx_cnt_q - 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q        <= IDLE;
         bit_cnt_q      <= '0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         rd_addr_flag_q <= 1'b0;
         tx_cnt_q       <= '0;
         miso_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         rd_addr_flag_q <= rd_addr_flag_d;
         tx_cnt_q       <= tx_cnt_d;
         miso_q         <= miso_d;
      end
   end

   assign MISO = miso_q;

endmodule

// File: tb/tb_spi_wrapper.sv
// Directed bench for spi_wrapper: table of full frames plus abort and mid-readout reset sequences.
// Ports: none (top-level bench).
// Latency/backpressure: not applicable.
module tb_spi_wrapper;
   import spi_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic SS_n;
   logic MOSI;
   logic MISO;

   int n_chk  = 0;
   int n_fail = 0;
   int rxv_cnt = 0;

   always #5 clk = ~clk;

   spi_wrapper dut (
      .clk   (clk),
      .rst_n (rst_n),
      .SS_n  (SS_n),
      .MOSI  (MOSI),
      .MISO  (MISO)
   );

   // Counts every cycle rx_valid is high, so a two-cycle pulse shows up as a delta of 2.
   always @(posedge clk) begin
      if (dut.rx_valid_q) rxv_cnt <= rxv_cnt + 1;
   end

   typedef struct {
      logic       sel;
      logic [9:0] bits;
      logic [7:0] exp_wr;
      logic [7:0] exp_rd;
      logic       exp_flag;
      logic       exp_tx;
      logic [7:0] exp_miso;
   } vec_t;

   vec_t tbl [14];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic run_frame(input int idx, input vec_t v);
      int         rx_before;
      logic [7:0] byte_v;
      rx_before = rxv_cnt;
      SS_n = 1'b0;
      MOSI = 1'b0;
      tick();
      MOSI = v.sel;
      tick();
      for (int i = 9; i >= 0; i--) begin
         MOSI = v.bits[i];
         tick();
      end
      MOSI = 1'($urandom_range(0, 1));
      tick();
      check($sformatf("v%0d tx_valid", idx), 32'(dut.u_ram.tx_valid_q), 32'(v.exp_tx));
      for (int b = 7; b >= 0; b--) begin
         MOSI = 1'($urandom_range(0, 1));
         tick();
         byte_v[b] = MISO;
      end
      check($sformatf("v%0d miso_byte", idx), 32'(byte_v), 32'(v.exp_miso));
      tick();
      check($sformatf("v%0d miso_tail", idx), 32'(MISO), 32'd0);
      SS_n = 1'b1;
      tick();
      check($sformatf("v%0d rx_valid_pulses", idx), 32'(rxv_cnt - rx_before), 32'd1);
      check($sformatf("v%0d wr_addr", idx), 32'(dut.u_ram.wr_addr_q), 32'(v.exp_wr));
      check($sformatf("v%0d rd_addr", idx), 32'(dut.u_ram.rd_addr_q), 32'(v.exp_rd));
      check($sformatf("v%0d rd_addr_flag", idx), 32'(dut.rd_addr_flag_q), 32'(v.exp_flag));
   endtask

   initial begin
      int   rx_before;
      vec_t v;

      //         sel   bits            wr     rd     flag  tx    miso
      tbl[0]  = '{1'b0, 10'b00_01011010, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 10'b01_11000011, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h00};
      tbl[2]  = '{1'b1, 10'b10_01011010, 8'h5A, 8'h5A, 1'b1, 1'b0, 8'h00};
      tbl[3]  = '{1'b1, 10'b11_00000000, 8'h5A, 8'h5A, 1'b0, 1'b1, 8'hC3};
      tbl[4]  = '{1'b0, 10'b00_11111111, 8'hFF, 8'h5A, 1'b0, 1'b0, 8'h00};
      tbl[5]  = '{1'b0, 10'b01_00000001, 8'hFF, 8'h5A, 1'b0, 1'b0, 8'h00};
      tbl[6]  = '{1'b1, 10'b10_11111111, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00};
      tbl[7]  = '{1'b1, 10'b11_10101010, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'h01};
      tbl[8]  = '{1'b0, 10'b00_00000000, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00};
      tbl[9]  = '{1'b0, 10'b01_10000000, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00};
      tbl[10] = '{1'b1, 10'b10_00000000, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00};
      tbl[11] = '{1'b1, 10'b11_00000000, 8'h00, 8'h00, 1'b0, 1'b1, 8'h80};
      tbl[12] = '{1'b1, 10'b10_01011010, 8'h00, 8'h5A, 1'b1, 1'b0, 8'h00};
      tbl[13] = '{1'b1, 10'b11_11111111, 8'h00, 8'h5A, 1'b0, 1'b1, 8'hC3};

      rst_n = 1'b1;
      SS_n  = 1'b1;
      MOSI  = 1'b0;
      tick();
      tick();
      check("reset state", 32'(dut.state_q), 32'(IDLE));
      check("reset MISO", 32'(MISO), 32'd0);
      check("reset rx_valid", 32'(dut.rx_valid_q), 32'd0);
      check("reset tx_valid", 32'(dut.u_ram.tx_valid_q), 32'd0);
      check("reset rd_addr_flag", 32'(dut.rd_addr_flag_q), 32'd0);
      check("reset wr_addr", 32'(dut.u_ram.wr_addr_q), 32'd0);
      rst_n = 1'b0;
      tick();

      for (int i = 0; i < 14; i++) run_frame(i, tbl[i]);

      // Abort a 01 frame after 5 bits: no write, no rx_valid, FSM back to IDLE.
      rx_before = rxv_cnt;
      SS_n = 1'b0;
      MOSI = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         MOSI = (i == 1);
         tick();
      end
      SS_n = 1'b1;
      tick();
      check("abort state", 32'(dut.state_q), 32'(IDLE));
      check("abort bit_cnt", 32'(dut.bit_cnt_q), 32'd0);
      tick();
      check("abort rx_valid", 32'(rxv_cnt - rx_before), 32'd0);
      check("abort mem", 32'(dut.u_ram.mem[0]), 32'h80);

      // A full frame after the abort must frame correctly from a cleared counter.
      v = '{1'b0, 10'b01_01010101, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h00};
      run_frame(100, v);
      check("post-abort mem", 32'(dut.u_ram.mem[0]), 32'h55);

      // Reset during read-data shift-out of 0x55.
      v = '{1'b1, 10'b10_00000000, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00};
      run_frame(101, v);
      SS_n = 1'b0;
      MOSI = 1'b0;
      tick();
      MOSI = 1'b1;
      tick();
      for (int i = 9; i >= 0; i--) begin
         MOSI = (i >= 8);
         tick();
      end
      MOSI = 1'b0;
      tick();
      check("rst-seq tx_valid", 32'(dut.u_ram.tx_valid_q), 32'd1);
      tick();
      check("rst-seq miso bit7", 32'(MISO), 32'd0);
      tick();
      check("rst-seq miso bit6", 32'(MISO), 32'd1);
      rst_n = 1'b1;
      tick();
      check("mid-read reset MISO", 32'(MISO), 32'd0);
      check("mid-read reset state", 32'(dut.state_q), 32'(IDLE));
      check("mid-read reset tx_valid", 32'(dut.u_ram.tx_valid_q), 32'd0);
      check("mid-read reset rd_addr", 32'(dut.u_ram.rd_addr_q), 32'd0);
      check("mid-read reset dout", 32'(dut.u_ram.dout_q), 32'd0);
      rst_n = 1'b0;
      tick();
      check("post-reset MISO", 32'(MISO), 32'd0);
      SS_n = 1'b1;
      tick();
      check("reset keeps mem", 32'(dut.u_ram.mem[0]), 32'h55);
      check("reset keeps mem 5A", 32'(dut.u_ram.mem[8'h5A]), 32'hC3);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
